seq_add_ctrl: RTL and testbench

Multi-cycle sequencer that performs wide add/subtract using one shared 8-bit ripple adder (x, y, cin -> s, cout), one byte per clock, LSB first. The adder stays a separate combinational instance. This block drives the adder's operand and carry inputs, captures each byte result, and chains the carry between bytes. It gives the requester a start/busy/done interface and 8*NBYTES-bit results.

---
 rtl/seq_add_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_add_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_add_ctrl.sv
// Wide add/subtract sequencer that reuses one external 8-bit adder, one byte per clock,
// LSB first. It chains the carry between bytes and assembles the result in sum.
module seq_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic [7:0]          add_x,
  output logic [7:0]          add_y,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            carry_reg, carry_next;
  logic [W-1:0]    a_lat_reg, a_lat_next;
  logic [W-1:0]    b_lat_reg, b_lat_next;
  logic            sub_lat_reg, sub_lat_next;
  logic [W-1:0]    sum_reg, sum_next;
  logic            cout_reg, cout_next;

  logic [7:0]        a_bytes [NBYTES];
  logic [7:0]        b_bytes [NBYTES];
  logic [NBYTES-1:0] byte_we;
  logic [W-1:0]      sum_upd;
  logic              last_byte;

  // Byte views of the latched operands and the progressive write-back of the result.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign a_bytes[gi]          = a_lat_reg[8*gi +: 8];
      assign b_bytes[gi]          = b_lat_reg[8*gi +: 8];
      assign byte_we[gi]          = (state_reg == RUN) && (idx_reg == IW'(gi));
      assign sum_upd[8*gi +: 8]   = byte_we[gi] ? add_s : sum_reg[8*gi +: 8];
    end
  endgenerate

  assign last_byte = (idx_reg == IW'(NBYTES - 1));

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    carry_next   = carry_reg;
    a_lat_next   = a_lat_reg;
    b_lat_next   = b_lat_reg;
    sub_lat_next = sub_lat_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
    busy         = 1'b0;
    done         = 1'b0;
    add_x        = 8'd0;
    add_y        = 8'd0;
    add_cin      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_lat_next   = a;
          b_lat_next   = b;
          sub_lat_next = sub;
          // Subtract is a + ~b + 1, so a borrow-in of 1 becomes a carry-in of 0.
          carry_next   = sub ? ~cin : cin;
          idx_next     = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        add_x      = a_bytes[idx_reg];
        add_y      = sub_lat_reg ? ~b_bytes[idx_reg] : b_bytes[idx_reg];
        add_cin    = carry_reg;
        sum_next   = sum_upd;
        carry_next = add_cout;
        idx_next   = idx_reg + IW'(1);
        if (last_byte) begin
          cout_next  = add_cout;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      carry_reg   <= 1'b0;
      a_lat_reg   <= '0;
      b_lat_reg   <= '0;
      sub_lat_reg <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      carry_reg   <= carry_next;
      a_lat_reg   <= a_lat_next;
      b_lat_reg   <= b_lat_next;
      sub_lat_reg <= sub_lat_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed-vector bench for seq_add_ctrl (NBYTES = 4) with a behavioural 8-bit adder
// attached to the adder ports.
module tb_seq_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_add_ctrl #(.NBYTES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
      $display("ok   %-24s got %08h", tag, obs);
    end else begin
      $display("FAIL %-24s got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present an operation and hold start through one edge; returns in RUN cycle 0.
  task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic c);
    sub   = s;
    a     = av;
    b     = bv;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walk the RUN cycles, the DONE cycle and the following IDLE cycle.
  task automatic run_body(input string tag, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic c, input logic [31:0] es,
                          input logic ec, input bit poke, input bit hold);
    logic       carry;
    logic [7:0] xb;
    logic [7:0] yb;
    logic [8:0] r;
    carry = s ? ~c : c;
    for (int i = 0; i < 4; i++) begin
      xb = av[8*i +: 8];
      yb = s ? ~bv[8*i +: 8] : bv[8*i +: 8];
      check($sformatf("%s busy%0d", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s done%0d", tag, i), {31'd0, done}, 32'd0);
      check($sformatf("%s add_x%0d", tag, i), {24'd0, add_x}, {24'd0, xb});
      check($sformatf("%s add_y%0d", tag, i), {24'd0, add_y}, {24'd0, yb});
      check($sformatf("%s add_cin%0d", tag, i), {31'd0, add_cin}, {31'd0, carry});
      r = {1'b0, xb} + {1'b0, yb} + {8'd0, carry};
      carry = r[8];
      if (poke && i == 2) begin
        start = 1'b1;
        sub   = ~s;
        a     = 32'hDEADBEEF;
        b     = 32'h01010101;
        cin   = ~c;
      end
      @(posedge clk); #1;
      if (poke) start = 1'b0;
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, " add_x_idle"}, {24'd0, add_x}, 32'd0);
    if (poke || hold) start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check({tag, " done_after"}, {31'd0, done}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " sum_hold"}, sum, es);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst sum", sum, 32'd0);
    check("rst cout", {31'd0, cout}, 32'd0);
    check("rst add_x", {24'd0, add_x}, 32'd0);
    check("rst add_y", {24'd0, add_y}, 32'd0);
    check("rst add_cin", {31'd0, add_cin}, 32'd0);
    // start alongside reset must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    check("rst_start busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    launch(1'b0, 32'h000000FF, 32'h00000001, 1'b0);
    run_body("ripple", 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 0, 0);

    launch(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_body("wrap1", 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 0, 0);

    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_body("wrap2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 0, 0);

    launch(1'b1, 32'h00000005, 32'h00000007, 1'b0);
    run_body("sub_borrow", 1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 0, 0);

    launch(1'b1, 32'h12345678, 32'h11111111, 1'b1);
    run_body("sub_bin", 1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h01234566, 1'b1, 0, 0);

    launch(1'b0, 32'h12345678, 32'h11111111, 1'b0);
    run_body("ports", 1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 0, 0);

    // start pulses during RUN and DONE are ignored
    launch(1'b0, 32'h000000FF, 32'h00000001, 1'b0);
    run_body("ignore", 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1, 0);

    // start held through done: next operation is taken in the IDLE cycle after done;
    // inputs change right after acceptance without disturbing the first operation
    launch(1'b0, 32'h000000FF, 32'h00000001, 1'b0);
    a   = 32'h12345678;
    b   = 32'h11111111;
    sub = 1'b0;
    cin = 1'b0;
    run_body("hold_a", 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    run_body("hold_b", 1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 0, 0);

    // reset during the third RUN cycle
    launch(1'b0, 32'h01020304, 32'h10203040, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst sum", sum, 32'd0);
    check("midrst cout", {31'd0, cout}, 32'd0);
    check("midrst add_x", {24'd0, add_x}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst no_done%0d", i), {31'd0, done}, 32'd0);
    end
    launch(1'b0, 32'h80000000, 32'h80000000, 1'b0);
    run_body("post_rst", 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
